// File: rtl/mdr_iter_pkg.sv
// Shared types for the iterative multiply / divide / square-root unit.
// Operation encodings match the front-panel op switches.
package mdr_iter_pkg;

    typedef enum logic [1:0] {
        MULT = 2'd0,
        DIV  = 2'd1,
        ROOT = 2'd2,
        RSVD = 2'd3
    } op_select_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_X,
        WAIT_Y,
        SETUP,
        ITER,
        DONE
    } mdr_state_t;

endpackage

// File: rtl/mdr_iter_ctrl.sv
// Sequencer for mdr_iter: operand request handshake, iteration counter,
// and the busy/done indications.
module mdr_iter_ctrl
    import mdr_iter_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       load,
    input  op_select_t op_in,
    input  logic       setup_err,
    output mdr_state_t state,
    output op_select_t op,
    output logic       last_iter,
    output logic       load_x,
    output logic       load_y,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(DW);

    mdr_state_t      state_reg, state_next;
    op_select_t      op_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   n_last;

    assign n_last    = (op_reg == ROOT) ? CW'(DW/2 - 1) : CW'(DW - 1);
    assign last_iter = (state_reg == ITER) && (cnt_reg == n_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            op_reg    <= MULT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start)
                op_reg <= op_in;
            cnt_reg <= (state_reg == ITER) ? cnt_reg + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_x     = 1'b0;
        load_y     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = (op_in == RSVD) ? DONE : WAIT_X;
            end
            WAIT_X: begin
                load_x = 1'b1;
                busy   = 1'b1;
                if (load)
                    state_next = (op_reg == ROOT) ? SETUP : WAIT_Y;
            end
            WAIT_Y: begin
                load_y = 1'b1;
                busy   = 1'b1;
                if (load)
                    state_next = SETUP;
            end
            SETUP: begin
                busy       = 1'b1;
                state_next = setup_err ? DONE : ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (last_iter)
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign state = state_reg;
    assign op    = op_reg;

endmodule

// File: rtl/mdr_iter.sv
// Iterative multiply / divide / square-root unit, one result bit per cycle.
// Works on magnitudes internally and applies the sign fix-up on the last step.
module mdr_iter
    import mdr_iter_pkg::*;
#(
    parameter int DW        = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_load,
    input  logic [DW-1:0]   i_data,
    input  logic [1:0]      i_op,
    output logic            o_load_x,
    output logic            o_load_y,
    output logic            o_busy,
    output logic            o_done,
    output logic [2*DW-1:0] o_result,
    output logic [DW-1:0]   o_remainder,
    output logic            o_error
);
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    mdr_state_t state;
    op_select_t op;
    logic       last_iter, setup_err;

    logic [DW-1:0]   x_reg, y_reg, hi_reg, lo_reg, ym_reg;
    logic [DW/2-1:0] root_reg;
    logic            neg_res_reg, neg_rem_reg;
    logic [2*DW-1:0] result_reg;
    logic [DW-1:0]   rem_reg;
    logic            error_reg;

    mdr_iter_ctrl #(.DW(DW)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (i_start),
        .load      (i_load),
        .op_in     (op_select_t'(i_op)),
        .setup_err (setup_err),
        .state     (state),
        .op        (op),
        .last_iter (last_iter),
        .load_x    (o_load_x),
        .load_y    (o_load_y),
        .busy      (o_busy),
        .done      (o_done)
    );

    logic          neg_x, neg_y;
    logic [DW-1:0] mag_x, mag_y;

    assign neg_x = SIGNED_EN && x_reg[DW-1];
    assign neg_y = SIGNED_EN && y_reg[DW-1];
    assign mag_x = neg_x ? -x_reg : x_reg;
    assign mag_y = neg_y ? -y_reg : y_reg;

    assign setup_err = ((op == DIV) && ((y_reg == '0) ||
                        (SIGNED_EN && (x_reg == MIN_NEG) && (y_reg == '1)))) ||
                       ((op == ROOT) && neg_x);

    // One iteration of whichever algorithm is active.
    logic [DW:0]     mul_sum, div_shift, div_diff;
    logic [DW+1:0]   rt_acc, rt_trial, rt_diff;
    logic [DW-1:0]   hi_step, lo_step;
    logic [DW/2-1:0] root_step;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? ym_reg : '0)};
        div_shift = {hi_reg, lo_reg[DW-1]};
        div_diff  = div_shift - {1'b0, ym_reg};
        rt_acc    = {hi_reg, lo_reg[DW-1:DW-2]};
        rt_trial  = {{(DW/2){1'b0}}, root_reg, 2'b01};
        rt_diff   = rt_acc - rt_trial;
        hi_step   = hi_reg;
        lo_step   = lo_reg;
        root_step = root_reg;
        case (op)
            MULT: begin
                hi_step = mul_sum[DW:1];
                lo_step = {mul_sum[0], lo_reg[DW-1:1]};
            end
            DIV: begin
                lo_step = {lo_reg[DW-2:0], ~div_diff[DW]};
                hi_step = div_diff[DW] ? div_shift[DW-1:0] : div_diff[DW-1:0];
            end
            ROOT: begin
                lo_step = {lo_reg[DW-3:0], 2'b00};
                if (rt_acc >= rt_trial) begin
                    hi_step   = rt_diff[DW-1:0];
                    root_step = {root_reg[DW/2-2:0], 1'b1};
                end else begin
                    hi_step   = rt_acc[DW-1:0];
                    root_step = {root_reg[DW/2-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    // Sign fix-up applied to the final iteration's values.
    logic [2*DW-1:0] prod, fix_result;
    logic [DW-1:0]   quo, fix_rem;

    always_comb begin
        prod       = {hi_step, lo_step};
        quo        = neg_res_reg ? -lo_step : lo_step;
        fix_result = '0;
        fix_rem    = '0;
        case (op)
            MULT: fix_result = neg_res_reg ? -prod : prod;
            DIV: begin
                fix_result = {{DW{SIGNED_EN && quo[DW-1]}}, quo};
                fix_rem    = neg_rem_reg ? -hi_step : hi_step;
            end
            ROOT: begin
                fix_result = {{(DW + DW/2){1'b0}}, root_step};
                fix_rem    = hi_step;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg       <= '0;
            y_reg       <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            ym_reg      <= '0;
            root_reg    <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            result_reg  <= '0;
            rem_reg     <= '0;
            error_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        result_reg <= '0;
                        rem_reg    <= '0;
                        error_reg  <= (op_select_t'(i_op) == RSVD);
                    end
                end
                WAIT_X: if (i_load) x_reg <= i_data;
                WAIT_Y: if (i_load) y_reg <= i_data;
                SETUP: begin
                    hi_reg      <= '0;
                    lo_reg      <= mag_x;
                    ym_reg      <= mag_y;
                    root_reg    <= '0;
                    neg_res_reg <= neg_x ^ neg_y;
                    neg_rem_reg <= neg_x;
                    if (setup_err)
                        error_reg <= 1'b1;
                end
                ITER: begin
                    hi_reg   <= hi_step;
                    lo_reg   <= lo_step;
                    root_reg <= root_step;
                    if (last_iter) begin
                        result_reg <= fix_result;
                        rem_reg    <= fix_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result    = result_reg;
    assign o_remainder = rem_reg;
    assign o_error     = error_reg;

endmodule

// File: tb/tb_mdr_iter.sv
// Directed bench for mdr_iter (DW=16, signed): arithmetic results, latency,
// handshake requests, error cases, ignored inputs and asynchronous reset.
module tb_mdr_iter;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_start = 1'b0;
    logic            i_load = 1'b0;
    logic [DW-1:0]   i_data = '0;
    logic [1:0]      i_op = 2'd0;
    logic            o_load_x, o_load_y, o_busy, o_done, o_error;
    logic [2*DW-1:0] o_result;
    logic [DW-1:0]   o_remainder;

    int checks = 0;
    int failures = 0;
    int rises_x = 0;
    int rises_y = 0;
    int both_hi = 0;
    logic prev_x = 1'b0;
    logic prev_y = 1'b0;

    always #5 clk = ~clk;

    mdr_iter #(.DW(DW), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_load      (i_load),
        .i_data      (i_data),
        .i_op        (i_op),
        .o_load_x    (o_load_x),
        .o_load_y    (o_load_y),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_remainder (o_remainder),
        .o_error     (o_error)
    );

    always @(negedge clk) begin
        if (o_load_x && !prev_x) rises_x++;
        if (o_load_y && !prev_y) rises_y++;
        if (o_load_x && o_load_y) both_hi++;
        prev_x = o_load_x;
        prev_y = o_load_y;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation; noise pulses i_start in WAIT_Y and ITER, same_load
    // drives i_load together with i_start in IDLE.
    task automatic run_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                          input bit noise, input bit same_load, output int lat);
        int nloads;
        nloads = (op == 2'd3) ? 0 : (op == 2'd2) ? 1 : 2;
        @(negedge clk);
        i_start = 1'b1;
        i_op    = op;
        if (same_load) begin
            i_load = 1'b1;
            i_data = 16'h1234;
        end
        @(negedge clk);
        i_start = 1'b0;
        i_load  = 1'b0;
        if (nloads > 0) begin
            chk("err_clr_on_start", 64'(o_error), 64'(0));
            chk("res_clr_on_start", 64'(o_result), 64'(0));
            chk("req_x", 64'(o_load_x), 64'(1));
            chk("no_req_y_in_x", 64'(o_load_y), 64'(0));
            i_load = 1'b1;
            i_data = x;
            @(negedge clk);
            if (nloads == 2) begin
                if (noise) begin
                    i_load  = 1'b0;
                    i_start = 1'b1;
                    i_op    = 2'd3;
                    @(negedge clk);
                    i_start = 1'b0;
                end
                chk("req_y", 64'(o_load_y), 64'(1));
                chk("no_req_x_in_y", 64'(o_load_x), 64'(0));
                i_load = 1'b1;
                i_data = y;
                @(negedge clk);
            end
            i_load = 1'b0;
        end
        lat = 1;
        while (o_done !== 1'b1 && lat < 40) begin
            i_start = (noise && lat == 5);
            i_op    = 2'd3;
            @(negedge clk);
            lat++;
        end
        i_start = 1'b0;
        chk("busy_low_at_done", 64'(o_busy), 64'(0));
    endtask

    task automatic check_txn(input string tag, input int lat, input int exp_lat,
                             input logic [31:0] exp_res, input logic [15:0] exp_rem,
                             input logic exp_err);
        $display("TXN %s result=%h rem=%h err=%0d latency=%0d", tag, o_result, o_remainder, o_error, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, 64'(o_result), 64'(exp_res));
        chk({tag, "_rem"}, 64'(o_remainder), 64'(exp_rem));
        chk({tag, "_err"}, 64'(o_error), 64'(exp_err));
    endtask

    initial begin
        int lat;
        int rx0, ry0;

        // Reset state
        #2;
        chk("rst_result", 64'(o_result), 64'(0));
        chk("rst_rem", 64'(o_remainder), 64'(0));
        chk("rst_err", 64'(o_error), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_loadx", 64'(o_load_x), 64'(0));
        chk("rst_loady", 64'(o_load_y), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        rx0 = rises_x; ry0 = rises_y;
        run_op(2'd0, 16'd25, 16'hFFFD, 1'b0, 1'b0, lat);
        check_txn("mult_25x-3", lat, 18, 32'hFFFF_FFB5, 16'h0000, 1'b0);
        chk("mult_req_x_once", 64'(rises_x - rx0), 64'(1));
        chk("mult_req_y_once", 64'(rises_y - ry0), 64'(1));

        run_op(2'd1, 16'hFFF9, 16'd2, 1'b0, 1'b0, lat);
        check_txn("div_-7/2", lat, 18, 32'hFFFF_FFFD, 16'hFFFF, 1'b0);

        run_op(2'd1, 16'd100, 16'd7, 1'b0, 1'b1, lat);
        check_txn("div_100/7", lat, 18, 32'h0000_000E, 16'h0002, 1'b0);

        ry0 = rises_y;
        run_op(2'd2, 16'd25, 16'd0, 1'b0, 1'b0, lat);
        check_txn("root_25", lat, 10, 32'd5, 16'd0, 1'b0);
        run_op(2'd2, 16'd26, 16'd0, 1'b0, 1'b0, lat);
        check_txn("root_26", lat, 10, 32'd5, 16'd1, 1'b0);
        repeat (2) @(negedge clk);
        chk("root_26_hold", 64'(o_result), 64'(5));
        run_op(2'd2, 16'h7FFF, 16'd0, 1'b0, 1'b0, lat);
        check_txn("root_7fff", lat, 10, 32'd181, 16'd6, 1'b0);
        chk("root_no_req_y", 64'(rises_y - ry0), 64'(0));

        run_op(2'd1, 16'd55, 16'd0, 1'b0, 1'b0, lat);
        check_txn("div_by_zero", lat, 2, 32'd0, 16'd0, 1'b1);
        run_op(2'd1, 16'h8000, 16'hFFFF, 1'b0, 1'b0, lat);
        check_txn("div_ovf", lat, 2, 32'd0, 16'd0, 1'b1);
        run_op(2'd2, 16'hFFFC, 16'd0, 1'b0, 1'b0, lat);
        check_txn("root_neg", lat, 2, 32'd0, 16'd0, 1'b1);

        rx0 = rises_x; ry0 = rises_y;
        run_op(2'd3, 16'd0, 16'd0, 1'b0, 1'b0, lat);
        check_txn("rsvd", lat, 1, 32'd0, 16'd0, 1'b1);
        chk("rsvd_no_req_x", 64'(rises_x - rx0), 64'(0));
        chk("rsvd_no_req_y", 64'(rises_y - ry0), 64'(0));

        run_op(2'd0, 16'hFFFC, 16'd5, 1'b1, 1'b0, lat);
        check_txn("mult_noise_-4x5", lat, 18, 32'hFFFF_FFEC, 16'd0, 1'b0);

        // Asynchronous reset in the middle of an iteration
        @(negedge clk);
        i_start = 1'b1; i_op = 2'd0;
        @(negedge clk);
        i_start = 1'b0; i_load = 1'b1; i_data = 16'd25;
        @(negedge clk);
        i_data = 16'hFFFD;
        @(negedge clk);
        i_load = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_iter_busy", 64'(o_busy), 64'(1));
        #1 rst = 1'b0;
        #1;
        chk("arst_busy", 64'(o_busy), 64'(0));
        chk("arst_done", 64'(o_done), 64'(0));
        chk("arst_loadx", 64'(o_load_x), 64'(0));
        chk("arst_loady", 64'(o_load_y), 64'(0));
        chk("arst_result", 64'(o_result), 64'(0));
        chk("arst_rem", 64'(o_remainder), 64'(0));
        chk("arst_err", 64'(o_error), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(2'd0, 16'd25, 16'd0, 1'b0, 1'b0, lat);
        check_txn("mult_25x0", lat, 18, 32'd0, 16'd0, 1'b0);

        chk("never_both_requests", 64'(both_hi), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
